// File: rtl/hilo_muldiv_unit_if.sv
// Request/response bundle for the HI/LO multiply-divide unit.
// The master drives the request; the slave returns status and the HI/LO registers.
interface hilo_muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [5:0]       ALU_operation;
    logic [WIDTH-1:0] input_1;
    logic [WIDTH-1:0] input_2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] ALU_HI_output;
    logic [WIDTH-1:0] ALU_LO_output;

    modport master (
        output start, ALU_operation, input_1, input_2,
        input  busy, done, ALU_HI_output, ALU_LO_output
    );

    modport slave (
        input  start, ALU_operation, input_1, input_2,
        output busy, done, ALU_HI_output, ALU_LO_output
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative MIPS-style HI/LO unit: shift-add multiply and restoring divide, one step per cycle,
// with sign handled by operating on magnitudes and correcting once in the final state.
module hilo_muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input logic              clk,
    input logic              reset,
    hilo_muldiv_unit_if.slave bus
);

    localparam logic [5:0] OpMult  = 6'b011000;
    localparam logic [5:0] OpMultu = 6'b011001;
    localparam logic [5:0] OpDiv   = 6'b011010;
    localparam logic [5:0] OpDivu  = 6'b011011;
    localparam logic [5:0] OpMthi  = 6'b010001;
    localparam logic [5:0] OpMtlo  = 6'b010011;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0] shr_q, shr_d;     // multiplier -> product low, or dividend -> quotient
    logic [WIDTH:0]   acc_q, acc_d;     // product high (with carry), or partial remainder
    logic             neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             is_mul_q, is_mul_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic             op_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, mul_sel, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_mag, prod;
    logic [WIDTH-1:0] quo, rem_mag, rem;
    logic             last_step;

    assign op_signed = (bus.ALU_operation == OpMult) || (bus.ALU_operation == OpDiv);
    assign a_neg     = op_signed & bus.input_1[WIDTH-1];
    assign b_neg     = op_signed & bus.input_2[WIDTH-1];
    assign a_mag     = a_neg ? -bus.input_1 : bus.input_1;
    assign b_mag     = b_neg ? -bus.input_2 : bus.input_2;

    assign mul_sum   = acc_q + {1'b0, opa_q};
    assign mul_sel   = shr_q[0] ? mul_sum : acc_q;
    assign div_shift = {acc_q[WIDTH-1:0], shr_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opa_q};

    assign prod_mag  = {acc_q[WIDTH-1:0], shr_q};
    assign prod      = neg_q ? -prod_mag : prod_mag;
    assign rem_mag   = acc_q[WIDTH-1:0];
    assign quo       = neg_q ? -shr_q : shr_q;
    assign rem       = rem_neg_q ? -rem_mag : rem_mag;
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opa_d     = opa_q;
        shr_d     = shr_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        is_mul_d  = is_mul_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    case (bus.ALU_operation)
                        OpMult, OpMultu: begin
                            opa_d     = a_mag;
                            shr_d     = b_mag;
                            acc_d     = '0;
                            neg_d     = a_neg ^ b_neg;
                            rem_neg_d = 1'b0;
                            is_mul_d  = 1'b1;
                            div0_d    = 1'b0;
                            cnt_d     = '0;
                            state_d   = StMul;
                        end
                        OpDiv, OpDivu: begin
                            is_mul_d = 1'b0;
                            cnt_d    = '0;
                            acc_d    = '0;
                            if (bus.input_2 == '0) begin
                                // Divide by zero bypasses iteration; the dividend is parked
                                // in the shift register so it can become HI.
                                shr_d   = bus.input_1;
                                div0_d  = 1'b1;
                                state_d = StFin;
                            end else begin
                                opa_d     = b_mag;
                                shr_d     = a_mag;
                                neg_d     = a_neg ^ b_neg;
                                rem_neg_d = a_neg;
                                div0_d    = 1'b0;
                                state_d   = StDiv;
                            end
                        end
                        OpMthi:  hi_d = bus.input_1;
                        OpMtlo:  lo_d = bus.input_1;
                        default: ;
                    endcase
                end
            end
            StMul: begin
                acc_d = {1'b0, mul_sel[WIDTH:1]};
                shr_d = {mul_sel[0], shr_q[WIDTH-1:1]};
                if (last_step) begin
                    cnt_d   = '0;
                    state_d = StFin;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDiv: begin
                if (!div_diff[WIDTH]) begin
                    acc_d = div_diff;
                    shr_d = {shr_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = div_shift;
                    shr_d = {shr_q[WIDTH-2:0], 1'b0};
                end
                if (last_step) begin
                    cnt_d   = '0;
                    state_d = StFin;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StFin: begin
                done_d  = 1'b1;
                state_d = StIdle;
                if (div0_q) begin
                    hi_d = shr_q;
                    lo_d = '1;
                end else if (is_mul_q) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            opa_q     <= '0;
            shr_q     <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            is_mul_q  <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opa_q     <= opa_d;
            shr_q     <= shr_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            is_mul_q  <= is_mul_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy          = (state_q == StMul) || (state_q == StDiv);
    assign bus.done          = done_q;
    assign bus.ALU_HI_output = hi_q;
    assign bus.ALU_LO_output = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench: stimulus queues expected HI/LO and completion cycle, monitors check on done.
module tb_hilo_muldiv_unit;

    localparam logic [5:0] OpMult  = 6'b011000;
    localparam logic [5:0] OpMultu = 6'b011001;
    localparam logic [5:0] OpDiv   = 6'b011010;
    localparam logic [5:0] OpDivu  = 6'b011011;
    localparam logic [5:0] OpMthi  = 6'b010001;
    localparam logic [5:0] OpMtlo  = 6'b010011;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cyc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;
    exp_t        q32[$];
    exp_t        q8[$];
    exp_t        e32, e8;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hilo_muldiv_unit_if #(.WIDTH(32)) bus32 ();
    hilo_muldiv_unit_if #(.WIDTH(8))  bus8 ();

    hilo_muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    hilo_muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitors: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus32.done === 1'b1) begin
            if (q32.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done32: got done at cycle %0d, expected none", cyc);
            end else begin
                e32 = q32.pop_front();
                check({e32.name, "_hi"}, bus32.ALU_HI_output, e32.hi);
                check({e32.name, "_lo"}, bus32.ALU_LO_output, e32.lo);
                check({e32.name, "_cyc"}, cyc, e32.cyc);
            end
        end
        if (bus8.done === 1'b1) begin
            if (q8.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done8: got done at cycle %0d, expected none", cyc);
            end else begin
                e8 = q8.pop_front();
                check({e8.name, "_hi"}, {24'h0, bus8.ALU_HI_output}, e8.hi);
                check({e8.name, "_lo"}, {24'h0, bus8.ALU_LO_output}, e8.lo);
                check({e8.name, "_cyc"}, cyc, e8.cyc);
            end
        end
    end

    task automatic issue32(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                           input string name, input bit exp_done, input logic [31:0] hi,
                           input logic [31:0] lo, input int unsigned lat);
        @(negedge clk);
        bus32.ALU_operation = op;
        bus32.input_1       = a;
        bus32.input_2       = b;
        bus32.start         = 1'b1;
        @(posedge clk);
        #1;
        bus32.start = 1'b0;
        if (exp_done) q32.push_back('{hi, lo, cyc + lat, name});
    endtask

    task automatic issue8(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                          input string name, input logic [7:0] hi, input logic [7:0] lo);
        @(negedge clk);
        bus8.ALU_operation = op;
        bus8.input_1       = a;
        bus8.input_2       = b;
        bus8.start         = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        q8.push_back('{{24'h0, hi}, {24'h0, lo}, cyc + 9, name});
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && (q32.size() != 0 || q8.size() != 0); i++) begin
            @(negedge clk);
            #1;
        end
        check({name, "_drained"}, q32.size() + q8.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset               = 1'b1;
        bus32.start         = 1'b0;
        bus32.ALU_operation = '0;
        bus32.input_1       = '0;
        bus32.input_2       = '0;
        bus8.start          = 1'b0;
        bus8.ALU_operation  = '0;
        bus8.input_1        = '0;
        bus8.input_2        = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'h0, bus32.busy}, 0);
        check("rst_done", {31'h0, bus32.done}, 0);
        check("rst_hi", bus32.ALU_HI_output, 0);
        check("rst_lo", bus32.ALU_LO_output, 0);
        check("rst8_hilo", {16'h0, bus8.ALU_HI_output, bus8.ALU_LO_output}, 0);
        reset = 1'b0;

        issue32(OpMthi, 32'hDEADBEEF, 32'h0, "mthi", 1'b0, 0, 0, 0);
        check("mthi_hi", bus32.ALU_HI_output, 32'hDEADBEEF);
        check("mthi_busy", {31'h0, bus32.busy}, 0);
        issue32(OpMtlo, 32'h01234567, 32'h0, "mtlo", 1'b0, 0, 0, 0);
        check("mtlo_lo", bus32.ALU_LO_output, 32'h01234567);
        check("mtlo_hi_kept", bus32.ALU_HI_output, 32'hDEADBEEF);

        issue32(OpMult, 32'hFFFFFFFE, 32'h3, "mult", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA, 33);
        check("mult_busy", {31'h0, bus32.busy}, 1);
        bus32.input_1 = 32'h12345678;
        bus32.input_2 = 32'h0;
        repeat (3) @(negedge clk);
        check("mult_hi_held", bus32.ALU_HI_output, 32'hDEADBEEF);
        check("mult_lo_held", bus32.ALU_LO_output, 32'h01234567);
        drain("mult");

        issue32(OpMultu, 32'hFFFFFFFE, 32'h3, "multu", 1'b1, 32'h2, 32'hFFFFFFFA, 33);
        drain("multu");
        issue32(OpDiv, 32'hFFFFFFF9, 32'h2, "div_m7_2", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        drain("div_m7_2");
        issue32(OpDiv, 32'h7, 32'hFFFFFFFE, "div_7_m2", 1'b1, 32'h1, 32'hFFFFFFFD, 33);
        drain("div_7_m2");
        issue32(OpDivu, 32'd100, 32'd7, "divu_100_7", 1'b1, 32'd2, 32'd14, 33);
        drain("divu_100_7");
        issue32(OpDiv, 32'h80000000, 32'hFFFFFFFF, "div_ovf", 1'b1, 32'h0, 32'h80000000, 33);
        drain("div_ovf");

        issue32(OpDivu, 32'd5, 32'd0, "divu_0", 1'b1, 32'd5, 32'hFFFFFFFF, 1);
        check("divu_0_busy_a", {31'h0, bus32.busy}, 0);
        @(negedge clk);
        check("divu_0_busy_b", {31'h0, bus32.busy}, 0);
        drain("divu_0");

        issue32(6'b000000, 32'hCAFEF00D, 32'h1, "badop", 1'b0, 0, 0, 0);
        check("badop_busy", {31'h0, bus32.busy}, 0);
        check("badop_hi", bus32.ALU_HI_output, 32'd5);
        check("badop_lo", bus32.ALU_LO_output, 32'hFFFFFFFF);

        // A start arriving mid-multiply is dropped, not queued.
        issue32(OpMult, 32'd7, 32'd6, "mult_ign", 1'b1, 32'h0, 32'd42, 33);
        repeat (5) @(negedge clk);
        bus32.ALU_operation = OpMthi;
        bus32.input_1       = 32'h1234;
        bus32.start         = 1'b1;
        @(posedge clk);
        #1;
        bus32.start = 1'b0;
        drain("mult_ign");
        repeat (3) @(negedge clk);
        check("ign_hi", bus32.ALU_HI_output, 32'h0);
        check("ign_lo", bus32.ALU_LO_output, 32'd42);

        issue8(OpMult, 8'h80, 8'h80, "mult8", 8'h40, 8'h00);
        drain("mult8");
        issue8(OpMultu, 8'hFF, 8'hFF, "multu8", 8'hFE, 8'h01);
        drain("multu8");
        issue8(OpDiv, 8'h80, 8'hFF, "div8_ovf", 8'h00, 8'h80);
        drain("div8_ovf");

        // Reset in the middle of a divide: no completion may follow.
        issue32(OpMthi, 32'h5555, 32'h0, "mthi2", 1'b0, 0, 0, 0);
        issue32(OpDiv, 32'd1000, 32'd3, "div_rst", 1'b0, 0, 0, 0);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_busy", {31'h0, bus32.busy}, 0);
        check("rst_mid_hi", bus32.ALU_HI_output, 0);
        check("rst_mid_lo", bus32.ALU_LO_output, 0);
        @(negedge clk);
        reset = 1'b0;
        issue32(OpMtlo, 32'hAA, 32'h0, "mtlo_aa", 1'b0, 0, 0, 0);
        check("post_rst_lo", bus32.ALU_LO_output, 32'hAA);
        check("post_rst_hi", bus32.ALU_HI_output, 32'h0);
        repeat (40) @(negedge clk);
        check("post_rst_busy", {31'h0, bus32.busy}, 0);
        drain("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
